// File: rtl/clock_pkg.sv
// Shared limits, mode encodings and BCD helper for the clock counter chain.
package clock_pkg;

  localparam int unsigned BCD_W = 8;

  localparam logic [BCD_W-1:0] BCD_MAX_SEC  = 8'h59;
  localparam logic [BCD_W-1:0] BCD_MAX_MIN  = 8'h59;
  localparam logic [BCD_W-1:0] BCD_MAX_HOUR = 8'h23;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_MIN = 2'b01,
    ST_SET_SEC = 2'b10
  } state_t;

  // Two-digit packed BCD increment without limit handling.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter that wraps at max back to 00; wrap flags the rollover step.
module bcd_mod60
  import clock_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = BCD_MAX_SEC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [BCD_W-1:0] q,
  output logic             wrap
);

  assign wrap = en && (q == MAX);

  always_ff @(posedge clk) begin
    if (!rst)      q <= '0;
    else if (wrap) q <= '0;
    else if (en)   q <= bcd_inc(q);
  end

endmodule

// File: rtl/clock_min_sec.sv
// Minutes/seconds timebase with set mode; co carries 59:59 -> 00:00 into the hour counter.
module clock_min_sec
  import clock_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             mode,
  input  logic             inc,
  output logic [BCD_W-1:0] sec,
  output logic [BCD_W-1:0] min,
  output logic             co,
  output logic [1:0]       setting
);

  state_t state, state_nxt;
  logic   sec_en, min_en;
  logic   sec_wrap, min_wrap;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // A mode press in a set state swallows any coincident inc.
  always_comb begin
    state_nxt = state;
    sec_en    = 1'b0;
    case (state)
      ST_RUN: begin
        sec_en = tick;
        if (mode) state_nxt = ST_SET_MIN;
      end
      ST_SET_MIN: begin
        if (mode) state_nxt = ST_SET_SEC;
      end
      ST_SET_SEC: begin
        sec_en = inc && !mode;
        if (mode) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Kept apart from the FSM block so sec_wrap does not feed back into it.
  assign min_en = (state == ST_RUN)     ? sec_wrap :
                  (state == ST_SET_MIN) ? (inc && !mode) : 1'b0;

  bcd_mod60 #(.MAX(BCD_MAX_SEC)) u_sec (
    .clk  (clk),
    .rst  (rst),
    .en   (sec_en),
    .q    (sec),
    .wrap (sec_wrap)
  );

  bcd_mod60 #(.MAX(BCD_MAX_MIN)) u_min (
    .clk  (clk),
    .rst  (rst),
    .en   (min_en),
    .q    (min),
    .wrap (min_wrap)
  );

  // min_wrap in RUN implies sec_wrap, i.e. a full 59:59 rollover.
  always_ff @(posedge clk) begin
    if (!rst) co <= 1'b0;
    else      co <= (state == ST_RUN) && min_wrap;
  end

  assign setting = 2'(state);

endmodule
